wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback-side driver for the register file's single write port (writereg/writedata/RegWrite). It merges two result sources into one registered write per cycle: the in-order MEM/WB pipeline result, which is never stalled, and a long-latency unit result (divider/load miss) delivered over a valid/ready handshake. Long-latency results that collide with pipeline writebacks wait in a small FIFO. A pending-destination mask is exported to hazard detection.

Parameters:
DEPTH, 4, long-latency result FIFO entries; power of two, at least 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
pipe_valid  input  1  MEM/WB result valid this cycle
pipe_rd  input  5  MEM/WB destination register
pipe_data  input  32  MEM/WB result data
lu_valid  input  1  long-latency result offered
lu_rd  input  5  long-latency destination register
lu_data  input  32  long-latency result data
lu_ready  output  1  long-latency result accepted this cycle
RegWrite  output  1  register file write enable (registered)
writereg  output  5  register file write address (registered)
writedata  output  32  register file write data (registered)
busy_mask  output  32  bit r=1 while a FIFO entry targets register r
fifo_count  output  CW  current FIFO occupancy

Behaviour:
- Reset: the asynchronous assert of rst clears RegWrite=0, writereg=0, writedata=0, the FIFO (count 0, read and write pointers 0), and busy_mask=0. lu_ready=0 while rst is high. Reset mid-operation discards all queued entries. No write is issued for discarded entries.
- Handshake: lu_ready = !rst && (fifo_count < DEPTH), derived only from registered state. A transfer occurs when lu_valid && lu_ready at a posedge.
- An accepted transfer with lu_rd==0 is consumed and dropped. It is never enqueued and never written.
- Per-posedge priority for the output register, highest first:
  1. pipe_valid && pipe_rd!=0: output takes the pipe result. An accepted LU transfer with nonzero rd is enqueued.
  2. Otherwise, if FIFO is non-empty: pop the head to the output. A simultaneous accepted LU transfer is pushed, so the count is unchanged.
  3. Otherwise, if the FIFO is empty and an accepted LU transfer has nonzero rd: bypass it straight to the output. Nothing is enqueued.
  4. Otherwise: RegWrite=0. writereg and writedata hold their previous values.
- pipe_valid with pipe_rd==0 counts as no pipe write, so the FIFO may drain that cycle.
- Latency:
  - Pipe result: visible on the outputs one posedge after presentation. The register file commits it on the following negedge.
  - Bypassed LU result: same one-posedge latency as a pipe result.
  - Queued LU result: written in the first cycle with no pipe write, in arrival order.
- Full: at count==DEPTH, lu_ready=0. A pop in that cycle does not raise lu_ready until the next cycle, because lu_ready depends on registered count only.
- busy_mask is the combinational OR of one-hot decodes of all valid FIFO entries. Duplicate rd entries keep the bit set until the last one pops. Entries already on the output register are not included.
- Ordering: two queued results for the same rd are written oldest first. Whether a pipe write may overtake a queued LU write to the same rd is the issue logic's responsibility, via busy_mask. This block does not check it.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.

Test Plan:
- Pipe only: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF for one cycle -> next posedge RegWrite=1, writereg=5, writedata=0xDEADBEEF; the cycle after, RegWrite=0.
- x0 suppression: pipe_rd=0 with data 0x1234, then LU handshake with lu_rd=0 -> RegWrite stays 0 throughout, lu_ready=1, fifo_count stays 0.
- LU bypass: FIFO empty, no pipe write, lu_valid=1, lu_rd=9, lu_data=0xA5A5A5A5 -> lu_ready=1, next posedge writereg=9 with data 0xA5A5A5A5, fifo_count=0, busy_mask=0.
- Collision: pipe (rd=3, 0x11) and LU (rd=7, 0x77) in the same cycle -> cycle+1 writes r3 with fifo_count=1 and busy_mask=0x80; cycle+2 writes r7 with busy_mask=0.
- Fill/drain, DEPTH=4: pipe_valid held with rd=1 while LU pushes rd=10..13 -> after the 4th push fifo_count=4 and lu_ready=0. Then drop pipe_valid -> r10, r11, r12, r13 are written on 4 consecutive cycles, and lu_ready returns to 1 the cycle after the first pop.
- Reset mid-operation: with 3 entries queued, pulse rst asynchronously between edges -> RegWrite, writereg and writedata go to 0 immediately, fifo_count=0, busy_mask=0, and no queued entry is ever written after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-side driver for the register file's single write port.
//
// This block merges two result sources into at most one registered write per cycle:
//   - the in-order MEM/WB pipeline result, which is never stalled, and
//   - a long-latency unit (LU) result, delivered over a valid/ready handshake.
// An LU result that collides with a pipeline write, or that arrives while older LU results
// are still queued, waits in a small FIFO. busy_mask tells hazard detection which
// registers have a queued LU write outstanding.
//
// Parameters:
//   DEPTH       LU result FIFO entries (power of two, at least 2)
//   CW          occupancy counter width, derived from DEPTH
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   pipe_*      MEM/WB result: valid, destination register, data
//   lu_*        LU result: valid, destination register, data, ready
//   RegWrite    registered register-file write enable
//   writereg    registered register-file write address
//   writedata   registered register-file write data
//   busy_mask   bit r is set while any queued FIFO entry targets register r
//   fifo_count  current FIFO occupancy
module wb_arbiter #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_valid,
  input  logic [4:0]    pipe_rd,
  input  logic [31:0]   pipe_data,
  input  logic          lu_valid,
  input  logic [4:0]    lu_rd,
  input  logic [31:0]   lu_data,
  output logic          lu_ready,
  output logic          RegWrite,
  output logic [4:0]    writereg,
  output logic [31:0]   writedata,
  output logic [31:0]   busy_mask,
  output logic [CW-1:0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic pipe_wr;  // pipe write to a real register (x0 writes are ignored)
  logic lu_take;  // accepted LU transfer that targets a real register
  logic fifo_ne;
  logic do_push, do_pop;

  assign fifo_count = count_q;
  assign fifo_ne    = (count_q != '0);

  // Depends on registered occupancy only, so a pop in a full cycle does not reopen the
  // handshake until the following cycle.
  assign lu_ready = !rst && (count_q < CW'(DEPTH));

  assign pipe_wr = pipe_valid && (pipe_rd != 5'd0);
  assign lu_take = lu_valid && lu_ready && (lu_rd != 5'd0);

  // The LU result is queued unless it can bypass straight to the output, which it can only
  // do when neither a pipe write nor an older queued result wants the port this cycle.
  assign do_pop  = !pipe_wr && fifo_ne;
  assign do_push = lu_take && (pipe_wr || fifo_ne);

  // One-hot decode of every valid entry between the read pointer and the occupancy.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        busy_mask[fifo_rd_q[rd_ptr_q + AW'(i)]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      writereg  <= '0;
      writedata <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      RegWrite <= 1'b0;
      if (pipe_wr) begin
        RegWrite  <= 1'b1;
        writereg  <= pipe_rd;
        writedata <= pipe_data;
      end else if (fifo_ne) begin
        RegWrite  <= 1'b1;
        writereg  <= fifo_rd_q[rd_ptr_q];
        writedata <= fifo_data_q[rd_ptr_q];
      end else if (lu_take) begin
        RegWrite  <= 1'b1;
        writereg  <= lu_rd;
        writedata <= lu_data;
      end

      if (do_push) begin
        fifo_rd_q[wr_ptr_q]   <= lu_rd;
        fifo_data_q[wr_ptr_q] <= lu_data;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (DEPTH = 4). Inputs change 1 ns after a posedge and
// outputs are sampled 1 ns after the following posedge.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pipe_valid = 1'b0;
  logic [4:0]    pipe_rd = '0;
  logic [31:0]   pipe_data = '0;
  logic          lu_valid = 1'b0;
  logic [4:0]    lu_rd = '0;
  logic [31:0]   lu_data = '0;
  logic          lu_ready;
  logic          RegWrite;
  logic [4:0]    writereg;
  logic [31:0]   writedata;
  logic [31:0]   busy_mask;
  logic [CW-1:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .RegWrite   (RegWrite),
    .writereg   (writereg),
    .writedata  (writedata),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid   = 1'b0; lu_rd   = '0; lu_data   = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    vectors++; if (writereg !== 5'd0) begin miscompares++; $display("FAIL reset_writereg got %0d want 0", writereg); end
    vectors++; if (writedata !== 32'd0) begin miscompares++; $display("FAIL reset_writedata got %h want 0", writedata); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_luready got %b want 0", lu_ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_luready got %b want 1", lu_ready); end
  endtask

  task automatic test_pipe_only();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL pipe_regwrite got %b want 1", RegWrite); end
    vectors++; if (writereg !== 5'd5) begin miscompares++; $display("FAIL pipe_writereg got %0d want 5", writereg); end
    vectors++; if (writedata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pipe_writedata got %h want deadbeef", writedata); end
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL pipe_after got %b want 0", RegWrite); end
    vectors++; if (writereg !== 5'd5) begin miscompares++; $display("FAIL pipe_hold_reg got %0d want 5", writereg); end
    vectors++; if (writedata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pipe_hold_data got %h want deadbeef", writedata); end
  endtask

  task automatic test_x0();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1234;
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_pipe_regwrite got %b want 0", RegWrite); end
    idle_inputs();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h5555;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_luready got %b want 1", lu_ready); end
    step();
    idle_inputs();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_lu_regwrite got %b want 0", RegWrite); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL x0_count got %0d want 0", fifo_count); end
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL x0_later got %b want 0", RegWrite); end
  endtask

  task automatic test_bypass();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hA5A5A5A5;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL byp_luready got %b want 1", lu_ready); end
    step();
    idle_inputs();
    vectors++; if (RegWrite !== 1'b1) begin miscompares++; $display("FAIL byp_regwrite got %b want 1", RegWrite); end
    vectors++; if (writereg !== 5'd9) begin miscompares++; $display("FAIL byp_writereg got %0d want 9", writereg); end
    vectors++; if (writedata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL byp_writedata got %h want a5a5a5a5", writedata); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL byp_count got %0d want 0", fifo_count); end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL byp_busy got %h want 0", busy_mask); end
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL byp_after got %b want 0", RegWrite); end
  endtask

  task automatic test_collision();
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h11;
    lu_valid   = 1'b1; lu_rd   = 5'd7; lu_data   = 32'h77;
    step();
    idle_inputs();
    vectors++; if (writereg !== 5'd3 || writedata !== 32'h11 || RegWrite !== 1'b1) begin
      miscompares++; $display("FAIL coll_first got we=%b r%0d=%h want we=1 r3=11", RegWrite, writereg, writedata); end
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL coll_count got %0d want 1", fifo_count); end
    vectors++; if (busy_mask !== 32'h80) begin miscompares++; $display("FAIL coll_busy got %h want 80", busy_mask); end
    step();
    vectors++; if (writereg !== 5'd7 || writedata !== 32'h77 || RegWrite !== 1'b1) begin
      miscompares++; $display("FAIL coll_second got we=%b r%0d=%h want we=1 r7=77", RegWrite, writereg, writedata); end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL coll_busy2 got %h want 0", busy_mask); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL coll_count2 got %0d want 0", fifo_count); end
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL coll_after got %b want 0", RegWrite); end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100 + k;
      lu_valid   = 1'b1; lu_rd   = 5'(10 + k); lu_data = 32'hA0 + k;
      vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL fill_luready[%0d] got %b want 1", k, lu_ready); end
      step();
      vectors++; if (writereg !== 5'd1 || writedata !== 32'h100 + k) begin
        miscompares++; $display("FAIL fill_pipe[%0d] got r%0d=%h want r1=%h", k, writereg, writedata, 32'h100 + k); end
    end
    idle_inputs();
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d want 4", fifo_count); end
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL full_luready got %b want 0", lu_ready); end
    vectors++; if (busy_mask !== 32'h3C00) begin miscompares++; $display("FAIL full_busy got %h want 3c00", busy_mask); end
    // First drain cycle presents a pipe write to x0, which must not block the pop.
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      idle_inputs();
      vectors++; if (RegWrite !== 1'b1 || writereg !== 5'(10 + k) || writedata !== 32'hA0 + k) begin
        miscompares++; $display("FAIL drain[%0d] got we=%b r%0d=%h want we=1 r%0d=%h",
                                k, RegWrite, writereg, writedata, 10 + k, 32'hA0 + k); end
      vectors++; if (fifo_count !== 3'(3 - k)) begin
        miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", k, fifo_count, 3 - k); end
      vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL drain_luready[%0d] got %b want 1", k, lu_ready); end
    end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL drain_busy got %h want 0", busy_mask); end
    step();
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL drain_after got %b want 0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
      lu_valid   = 1'b1; lu_rd   = 5'(20 + k); lu_data = 32'hC0 + k;
      step();
    end
    lu_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL mid_count got %0d want 3", fifo_count); end
    vectors++; if (busy_mask !== 32'h0070_0000) begin miscompares++; $display("FAIL mid_busy got %h want 00700000", busy_mask); end
    vectors++; if (RegWrite !== 1'b1 || writereg !== 5'd2) begin
      miscompares++; $display("FAIL mid_pre got we=%b r%0d want we=1 r2", RegWrite, writereg); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL mid_regwrite got %b want 0", RegWrite); end
    vectors++; if (writereg !== 5'd0) begin miscompares++; $display("FAIL mid_writereg got %0d want 0", writereg); end
    vectors++; if (writedata !== 32'd0) begin miscompares++; $display("FAIL mid_writedata got %h want 0", writedata); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_rcount got %0d want 0", fifo_count); end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL mid_rbusy got %h want 0", busy_mask); end
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL mid_luready got %b want 0", lu_ready); end
    #1 rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (RegWrite !== 1'b0) begin
        miscompares++; $display("FAIL mid_ghost[%0d] got we=%b r%0d want we=0", k, RegWrite, writereg); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_x0();
    test_bypass();
    test_collision();
    test_fill_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
